// File: rtl/brick_collide.sv
// Brick-field collision detector: latches the ball box on an animation strobe,
// scans one brick per clock, and reports the lowest-index hit as a bounce code.
module brick_collide #(
  parameter int N_BLOCKS = 17,
  parameter int COLS     = 6,
  parameter int X0       = 40,
  parameter int Y0       = 40,
  parameter int BW       = 80,
  parameter int BH       = 20,
  parameter int GAP      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ani_stb,
  input  logic                  i_animate,
  input  logic [11:0]           i_x1,
  input  logic [11:0]           i_x2,
  input  logic [11:0]           i_y1,
  input  logic [11:0]           i_y2,
  input  logic [N_BLOCKS-1:0]   i_dead,
  output logic [2*N_BLOCKS-1:0] o_hit_block,
  output logic                  o_hit_any,
  output logic                  o_busy
);

  localparam int KW = $clog2(N_BLOCKS + 1);
  localparam int CW = $clog2(COLS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
  state_t r_state, w_next;

  logic [11:0]           r_x1, r_x2, r_y1, r_y2;
  logic [N_BLOCKS-1:0]   r_dead;
  logic [KW-1:0]         r_k;
  logic [CW-1:0]         r_col;
  logic [11:0]           r_bx1, r_by1;
  logic                  r_cand_valid, r_cand_hit;
  logic [1:0]            r_cand_code;
  logic [KW-1:0]         r_cand_idx;
  logic                  r_pend_found;
  logic [1:0]            r_pend_code;
  logic [KW-1:0]         r_pend_idx;
  logic [2*N_BLOCKS-1:0] r_hit_block;
  logic                  r_hit_any, r_busy;

  logic                  w_accept, w_eval, w_scan_last, w_box_ok, w_overlap;
  logic [11:0]           w_bx2, w_by2, w_lo_x, w_hi_x, w_lo_y, w_hi_y, w_ox, w_oy;
  logic [1:0]            w_code;
  logic [2*N_BLOCKS-1:0] w_decoded;

  assign w_accept    = (r_state == S_IDLE) && i_ani_stb && i_animate;
  assign w_eval      = (r_state == S_SCAN) && (r_k < KW'(N_BLOCKS));
  assign w_scan_last = (r_k == KW'(N_BLOCKS));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SCAN;
      S_SCAN:  if (w_scan_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Overlap and bounce code for the brick currently addressed by r_k.
  assign w_bx2    = r_bx1 + 12'(BW - 1);
  assign w_by2    = r_by1 + 12'(BH - 1);
  assign w_box_ok = (r_x1 <= r_x2) && (r_y1 <= r_y2);
  assign w_overlap = w_box_ok && (r_x1 <= w_bx2) && (r_x2 >= r_bx1) &&
                     (r_y1 <= w_by2) && (r_y2 >= r_by1) && !r_dead[0];
  assign w_lo_x = (r_x1 > r_bx1) ? r_x1 : r_bx1;
  assign w_hi_x = (r_x2 < w_bx2) ? r_x2 : w_bx2;
  assign w_lo_y = (r_y1 > r_by1) ? r_y1 : r_by1;
  assign w_hi_y = (r_y2 < w_by2) ? r_y2 : w_by2;
  assign w_ox   = w_hi_x - w_lo_x;
  assign w_oy   = w_hi_y - w_lo_y;
  assign w_code = (w_oy < w_ox) ? 2'b01 : (w_ox < w_oy) ? 2'b10 : 2'b11;

  generate
    for (genvar gi = 0; gi < N_BLOCKS; gi++) begin : g_dec
      assign w_decoded[2*gi +: 2] =
        (r_pend_found && (r_pend_idx == KW'(gi))) ? r_pend_code : 2'b00;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x1 <= '0; r_x2 <= '0; r_y1 <= '0; r_y2 <= '0;
      r_dead <= '0; r_k <= '0; r_col <= '0; r_bx1 <= '0; r_by1 <= '0;
      r_cand_valid <= 1'b0; r_cand_hit <= 1'b0; r_cand_code <= '0; r_cand_idx <= '0;
      r_pend_found <= 1'b0; r_pend_code <= '0; r_pend_idx <= '0;
      r_hit_block <= '0; r_hit_any <= 1'b0; r_busy <= 1'b0;
    end else begin
      // Evaluation is registered, so commit trails the brick counter by one cycle.
      r_cand_valid <= w_eval;
      r_cand_hit   <= w_eval && w_overlap;
      r_cand_code  <= w_code;
      r_cand_idx   <= r_k;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x1 <= i_x1; r_x2 <= i_x2; r_y1 <= i_y1; r_y2 <= i_y2;
            r_dead       <= i_dead;
            r_hit_block  <= '0;
            r_hit_any    <= 1'b0;
            r_busy       <= 1'b1;
            r_k          <= '0;
            r_col        <= '0;
            r_bx1        <= 12'(X0);
            r_by1        <= 12'(Y0);
            r_pend_found <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_eval) begin
            r_k    <= r_k + 1'b1;
            r_dead <= r_dead >> 1;
            if (r_col == CW'(COLS - 1)) begin
              r_col <= '0;
              r_bx1 <= 12'(X0);
              r_by1 <= r_by1 + 12'(BH + GAP);
            end else begin
              r_col <= r_col + 1'b1;
              r_bx1 <= r_bx1 + 12'(BW + GAP);
            end
          end
          // First hit wins so opposing flips never reach the consumer together.
          if (r_cand_valid && r_cand_hit && !r_pend_found) begin
            r_pend_found <= 1'b1;
            r_pend_code  <= r_cand_code;
            r_pend_idx   <= r_cand_idx;
          end
        end
        S_DONE: begin
          r_hit_block <= w_decoded;
          r_hit_any   <= r_pend_found;
          r_busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_hit_block = r_hit_block;
  assign o_hit_any   = r_hit_any;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_brick_collide.sv
// Scoreboard bench for brick_collide: stimulus queues expected results,
// a negedge monitor checks each completed scan for value and latency.
module tb_brick_collide;
  localparam int N = 17;
  localparam int LAT = 19;

  logic          clk = 1'b0;
  logic          rst, stb, animate;
  logic [11:0]   x1, x2, y1, y2;
  logic [N-1:0]  dead;
  logic [2*N-1:0] hit_block;
  logic          hit_any, busy;

  always #5 clk = ~clk;

  brick_collide dut (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_animate(animate),
    .i_x1(x1), .i_x2(x2), .i_y1(y1), .i_y2(y2), .i_dead(dead),
    .o_hit_block(hit_block), .o_hit_any(hit_any), .o_busy(busy)
  );

  typedef struct {
    logic [2*N-1:0] vec;
    int             t0;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   abort_pending = 1'b0;
  bit   prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a falling o_busy marks a completed (or aborted) scan.
  always @(negedge clk) begin
    if (prev_busy && !busy) begin
      if (abort_pending) begin
        abort_pending = 1'b0;
        chk("abort_hit_block", 64'(hit_block), 64'd0);
        chk("abort_hit_any", 64'(hit_any), 64'd0);
        $display("txn abort: hit_block=0x%0h", hit_block);
      end else if (sb.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hit_block", 64'(hit_block), 64'(e.vec));
        chk("hit_any", 64'(hit_any), 64'(e.vec != '0));
        chk("latency", 64'(cyc - e.t0), 64'(LAT));
        $display("txn result: hit_block=0x%0h exp=0x%0h latency=%0d", hit_block, e.vec, cyc - e.t0);
      end
    end
    prev_busy = busy;
  end

  task automatic send(input int ax1, input int ax2, input int ay1, input int ay2,
                      input logic [N-1:0] adead, input logic [2*N-1:0] exp_vec);
    exp_t e;
    @(negedge clk);
    x1 = 12'(ax1); x2 = 12'(ax2); y1 = 12'(ay1); y2 = 12'(ay2);
    dead = adead; animate = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1;
    stb = 1'b0;
    e.vec = exp_vec;
    e.t0  = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || abort_pending) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("scan_timeout", 64'd1, 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stb = 1'b0; animate = 1'b0;
    x1 = '0; x2 = '0; y1 = '0; y2 = '0; dead = '0;
    repeat (3) @(negedge clk);
    chk("reset_hit_block", 64'(hit_block), 64'd0);
    chk("reset_hit_any", 64'(hit_any), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors: top, side, corner, dead, row 1, priority, miss, inverted, last brick.
    send(60, 79, 50, 69, '0, 34'h1);              wait_idle();
    send(110, 129, 42, 57, '0, 34'h2);            wait_idle();
    send(110, 129, 50, 69, '0, 34'h3);            wait_idle();
    send(60, 79, 50, 69, 17'h1, 34'h0);           wait_idle();
    send(60, 79, 80, 99, '0, 34'h1000);           wait_idle();
    send(100, 150, 50, 69, '0, 34'h1);            wait_idle();
    send(0, 10, 0, 10, '0, 34'h0);                wait_idle();
    send(79, 60, 50, 69, '0, 34'h0);              wait_idle();
    send(430, 439, 100, 115, '0, 34'h100000000);  wait_idle();

    // Dead mask changes mid-scan are ignored.
    send(60, 79, 50, 69, '0, 34'h1);
    @(negedge clk);
    dead = '1;
    wait_idle();
    dead = '0;

    // Result holds; strobe with animate low is ignored.
    repeat (4) @(negedge clk);
    chk("hold_hit_block", 64'(hit_block), 64'h1);
    animate = 1'b0; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    repeat (3) @(negedge clk);
    chk("noanim_busy", 64'(busy), 64'd0);
    chk("noanim_hit_block", 64'(hit_block), 64'h1);
    animate = 1'b1;

    // Strobe during scan is ignored: result and latency unchanged.
    send(110, 129, 42, 57, '0, 34'h2);
    repeat (5) @(negedge clk);
    x1 = 12'd60; x2 = 12'd79; y1 = 12'd80; y2 = 12'd99; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    wait_idle();

    // Reset mid-scan aborts with no partial result.
    send(60, 79, 50, 69, '0, 34'h1);
    repeat (7) @(negedge clk);
    void'(sb.pop_back());
    abort_pending = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_idle();
    chk("post_reset_hit_block", 64'(hit_block), 64'd0);
    send(110, 129, 50, 69, '0, 34'h3);            wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
